// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/response bundle between the execute stage and the
// iterative multiply/divide unit.
//   valid_i / ready_o    request handshake (accept on valid_i & ready_o & !flush_i)
//   funct3_i             operation select (M-extension funct3 encoding)
//   op1_i / op2_i        rs1 / rs2 operands
//   flush_i              abort any in-flight operation
//   valid_o / result_o   single-cycle completion pulse and result
// master = execute stage, slave = mdu_iter.
interface mdu_iter_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic            flush_i;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, funct3_i, op1_i, op2_i, flush_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  valid_i, funct3_i, op1_i, op2_i, flush_i,
    output ready_o, valid_o, result_o
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RISC-V M-extension multiply/divide unit.
// Operands are converted to magnitudes at acceptance; the core runs an
// unsigned shift-add multiply or restoring divide, one bit per cycle, and
// the sign fix-up plus result selection happen on the way out of DONE.
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-high reset
//   bus     mdu_iter_if.slave (handshake, operands, flush, result)
//
// state  | meaning
// IDLE   | ready_o high, waiting for a request
// CALC   | one multiply/divide iteration per cycle, XLEN cycles
// DONE   | fix-up signs, publish result_o and pulse valid_o on exit
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  mdu_iter_if.slave   bus
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_sel;
  logic [XLEN-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] prod;      // product high half | remaining multiplier bits
  logic [XLEN:0]     prem;      // partial remainder
  logic [XLEN-1:0]   quo;       // dividend bits shift out, quotient bits shift in
  logic              neg_res;   // product / quotient must be negated
  logic              neg_rem;   // remainder must be negated
  logic              valid_q;
  logic [XLEN-1:0]   result_q;

  // acceptance-side decode
  logic            accept;
  logic            is_div;
  logic            op1_sgn;
  logic            op2_sgn;
  logic            neg1;
  logic            neg2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            div_zero;
  logic            div_ovf;
  logic            special;

  // iteration datapath
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_diff;
  logic            div_ge;
  logic [CW-1:0]   cnt_nxt;

  // completion datapath
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_mag;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   res_sel;

  assign bus.ready_o  = (state == S_IDLE);
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;

  always_comb begin
    accept   = bus.valid_i && (state == S_IDLE) && !bus.flush_i;
    is_div   = bus.funct3_i[2];
    op1_sgn  = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b010) ||
               (bus.funct3_i == 3'b100) || (bus.funct3_i == 3'b110);
    op2_sgn  = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b100) ||
               (bus.funct3_i == 3'b110);
    neg1     = op1_sgn && bus.op1_i[XLEN-1];
    neg2     = op2_sgn && bus.op2_i[XLEN-1];
    mag1     = neg1 ? (~bus.op1_i + XLEN'(1)) : bus.op1_i;
    mag2     = neg2 ? (~bus.op2_i + XLEN'(1)) : bus.op2_i;
    div_zero = (bus.op2_i == '0);
    // only the signed forms (DIV/REM, funct3[0] = 0) can overflow
    div_ovf  = !bus.funct3_i[0] &&
               (bus.op1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
               (bus.op2_i == {XLEN{1'b1}});
    special  = is_div && (div_zero || div_ovf);
  end

  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    div_shift = {prem[XLEN-1:0], quo[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    div_ge    = !div_diff[XLEN+1];
    cnt_nxt   = cnt + CW'(1);
  end

  always_comb begin
    prod_fix = neg_res ? (~prod + (2*XLEN)'(1)) : prod;
    quo_fix  = neg_res ? (~quo + XLEN'(1)) : quo;
    rem_mag  = prem[XLEN-1:0];
    rem_fix  = neg_rem ? (~rem_mag + XLEN'(1)) : rem_mag;
    res_sel  = '0;
    case (op_sel)
      3'b000:                 res_sel = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_sel = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res_sel = quo_fix;
      default:                res_sel = rem_fix;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_sel   <= '0;
      opnd     <= '0;
      prod     <= '0;
      prem     <= '0;
      quo      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_sel <= bus.funct3_i;
            cnt    <= '0;
            if (special) begin
              // result is already known; hand it through DONE unsigned
              state   <= S_DONE;
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
              quo     <= div_zero ? {XLEN{1'b1}} : bus.op1_i;
              prem    <= div_zero ? {1'b0, bus.op1_i} : '0;
            end else begin
              state   <= S_CALC;
              neg_res <= neg1 ^ neg2;
              neg_rem <= neg1;
              if (is_div) begin
                opnd <= mag2;
                quo  <= mag1;
                prem <= '0;
              end else begin
                opnd <= mag1;
                prod <= {{XLEN{1'b0}}, mag2};
              end
            end
          end
        end

        S_CALC: begin
          if (bus.flush_i) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt_nxt;
            if (op_sel[2]) begin
              quo  <= {quo[XLEN-2:0], div_ge};
              prem <= div_ge ? div_diff[XLEN:0] : div_shift;
            end else begin
              prod <= {mul_sum, prod[XLEN-1:1]};
            end
            if (cnt_nxt == CW'(XLEN)) begin
              state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          if (!bus.flush_i) begin
            valid_q  <= 1'b1;
            result_q <= res_sel;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

  logic clk;
  logic rst;

  mdu_iter_if #(.XLEN(32)) bus ();

  mdu_iter #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'h0) ||
                    (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    int          ia;
    int          ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'({32'h0, b})); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called at posedge+1. Presents the request immediately if ready_o is
  // high, so consecutive calls run back-to-back.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name, input bit post_chk);
    int edges;
    int exp_lat;
    bit seen;
    bit rdy_low;
    edges = 0;
    while (!bus.ready_o && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!bus.ready_o) check({name, "_ready_wait"}, 32'(bus.ready_o), 32'd1);
    exp_lat = is_special(f, a, b) ? 1 : 33;
    bus.valid_i  = 1'b1;
    bus.funct3_i = f;
    bus.op1_i    = a;
    bus.op2_i    = b;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    edges   = 0;
    seen    = 1'b0;
    rdy_low = 1'b1;
    while (!seen && edges < 100) begin
      if (bus.ready_o) rdy_low = 1'b0;
      @(posedge clk); #1;
      edges++;
      bus.funct3_i = 3'($urandom);
      bus.op1_i    = $urandom;
      bus.op2_i    = $urandom;
      if (bus.valid_o) seen = 1'b1;
    end
    check({name, "_latency"}, 32'(edges), 32'(exp_lat));
    check({name, "_result"}, bus.result_o, exp);
    check({name, "_ready_low"}, 32'(rdy_low), 32'd1);
    last_res = exp;
    if (post_chk) begin
      @(posedge clk); #1;
      check({name, "_valid_single"}, 32'(bus.valid_o), 32'd0);
      check({name, "_ready_after"}, 32'(bus.ready_o), 32'd1);
    end
  endtask

  // Watches for valid_o over n cycles; returns 1 if it ever appeared.
  task automatic watch_no_valid(input int n, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (bus.valid_o) hit = 1'b1;
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[16];
    bit   hit;
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_signed_low"};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min"};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max"};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_max"};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_neg"};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_neg"};
    vecs[6]  = '{3'd5, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, "divu_small"};
    vecs[7]  = '{3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, "remu_big"};
    vecs[8]  = '{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "div_by_zero"};
    vecs[9]  = '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "remu_by_zero"};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow"};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_overflow"};
    vecs[12] = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, "rem_pos_by_neg"};
    vecs[13] = '{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_pos_by_neg"};
    vecs[14] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "divu_no_ovf"};
    vecs[15] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_neg_neg"};

    rst          = 1'b1;
    bus.valid_i  = 1'b0;
    bus.flush_i  = 1'b0;
    bus.funct3_i = 3'd0;
    bus.op1_i    = '0;
    bus.op2_i    = '0;
    #1;
    check("reset_ready", 32'(bus.ready_o), 32'd1);
    check("reset_valid", 32'(bus.valid_o), 32'd0);
    check("reset_result", bus.result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, 1'b1);
    end

    // flush 10 cycles into CALC
    bus.valid_i  = 1'b1;
    bus.funct3_i = 3'd0;
    bus.op1_i    = 32'h0000_1234;
    bus.op2_i    = 32'h0000_5678;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    check("flush_calc_ready", 32'(bus.ready_o), 32'd1);
    check("flush_calc_valid", 32'(bus.valid_o), 32'd0);
    watch_no_valid(40, hit);
    check("flush_calc_no_valid", 32'(hit), 32'd0);
    check("flush_calc_result_kept", bus.result_o, last_res);
    run_op(3'd3, 32'd3, 32'd5, 32'd0, "mulhu_after_flush", 1'b1);

    // flush while in DONE (special case goes straight there)
    bus.valid_i  = 1'b1;
    bus.funct3_i = 3'd4;
    bus.op1_i    = 32'd5;
    bus.op2_i    = 32'd0;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    check("flush_done_valid", 32'(bus.valid_o), 32'd0);
    check("flush_done_ready", 32'(bus.ready_o), 32'd1);
    watch_no_valid(5, hit);
    check("flush_done_no_valid", 32'(hit), 32'd0);
    check("flush_done_result_kept", bus.result_o, last_res);

    // flush together with a request in IDLE
    bus.valid_i  = 1'b1;
    bus.flush_i  = 1'b1;
    bus.funct3_i = 3'd7;
    bus.op1_i    = 32'd9;
    bus.op2_i    = 32'd0;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    check("flush_idle_not_accepted", 32'(bus.ready_o), 32'd1);
    watch_no_valid(40, hit);
    check("flush_idle_no_valid", 32'(hit), 32'd0);
    check("flush_idle_result_kept", bus.result_o, last_res);

    // asynchronous reset in the middle of CALC
    run_op(3'd5, 32'd7, 32'd2, 32'd3, "divu_before_reset", 1'b0);
    bus.valid_i  = 1'b1;
    bus.funct3_i = 3'd3;
    bus.op1_i    = 32'hDEAD_BEEF;
    bus.op2_i    = 32'h1234_5678;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("async_rst_ready", 32'(bus.ready_o), 32'd1);
    check("async_rst_valid", 32'(bus.valid_o), 32'd0);
    check("async_rst_result", bus.result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_no_valid(40, hit);
    check("async_rst_no_stale_valid", 32'(hit), 32'd0);
    last_res = '0;

    // randomised back-to-back operations
    for (int n = 0; n < 1000; n++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'hFFFF_FFFF;
        4: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_op(rf, ra, rb, ref_model(rf, ra, rb), "random", 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
